// File: rtl/rf_write_arbiter_if.sv
// Register-file writeback bus: two requesters (ALU, LSU) on one side,
// the arbitrated single write port and init status on the other.
interface rf_write_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32
);
  logic                  alu_req_i;
  logic [ADDR_WIDTH-1:0] alu_addr_i;
  logic [WORD_WIDTH-1:0] alu_data_i;
  logic                  alu_gnt_o;
  logic                  lsu_req_i;
  logic [ADDR_WIDTH-1:0] lsu_addr_i;
  logic [WORD_WIDTH-1:0] lsu_data_i;
  logic                  lsu_gnt_o;
  logic [ADDR_WIDTH-1:0] write_addr_o;
  logic [WORD_WIDTH-1:0] write_data_o;
  logic                  write_en_o;
  logic                  init_done_o;

  // Arbiter side
  modport slave (
    input  alu_req_i, alu_addr_i, alu_data_i,
    input  lsu_req_i, lsu_addr_i, lsu_data_i,
    output alu_gnt_o, lsu_gnt_o,
    output write_addr_o, write_data_o, write_en_o, init_done_o
  );

  // Requester / register-bank side
  modport master (
    output alu_req_i, alu_addr_i, alu_data_i,
    output lsu_req_i, lsu_addr_i, lsu_data_i,
    input  alu_gnt_o, lsu_gnt_o,
    input  write_addr_o, write_data_o, write_en_o, init_done_o
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter. After reset it clears registers 1..2^AW-1
// (register 0 is hard-wired zero and never written), then arbitrates
// ALU and LSU writebacks onto one registered write port. The LSU wins
// contention unless the ALU has lost STARVE_LIMIT times in a row.
module rf_write_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int WORD_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  rf_write_arbiter_if.slave bus
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
  localparam logic [3:0]            LIMIT     = 4'(STARVE_LIMIT);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [3:0]            starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [WORD_WIDTH-1:0] write_data_q, write_data_d;
  logic                  write_en_q, write_en_d;
  logic                  init_done_q, init_done_d;
  logic                  alu_win, lsu_win;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [WORD_WIDTH-1:0] win_data;

  // Next-state, arbitration and write-port staging
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    starve_d     = starve_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    write_en_d   = 1'b0;
    init_done_d  = init_done_q;
    alu_win      = 1'b0;
    lsu_win      = 1'b0;
    win_addr     = '0;
    win_data     = '0;

    case (state_q)
      ST_INIT: begin
        // One clear write per cycle; requesters simply wait ungranted.
        write_en_d   = 1'b1;
        write_addr_d = clr_addr_q;
        write_data_d = '0;
        clr_addr_d   = clr_addr_q + FIRST_ADDR;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Set on the first edge in RUN, i.e. one cycle after the last clear.
        init_done_d = 1'b1;

        if (bus.alu_req_i && bus.lsu_req_i) begin
          alu_win = (starve_q == LIMIT);
          lsu_win = !alu_win;
        end else begin
          alu_win = bus.alu_req_i;
          lsu_win = bus.lsu_req_i;
        end

        if (alu_win) begin
          starve_d = '0;
        end else if (lsu_win && bus.alu_req_i) begin
          starve_d = starve_q + 4'd1;
        end

        win_addr = alu_win ? bus.alu_addr_i : bus.lsu_addr_i;
        win_data = alu_win ? bus.alu_data_i : bus.lsu_data_i;

        // A write to register 0 is accepted but dropped; the port keeps
        // presenting the last real write.
        if ((alu_win || lsu_win) && (win_addr != '0)) begin
          write_en_d   = 1'b1;
          write_addr_d = win_addr;
          write_data_d = win_data;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // State and write-port registers; reset discards any staged write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      clr_addr_q   <= FIRST_ADDR;
      starve_q     <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
      write_en_q   <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      starve_q     <= starve_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      write_en_q   <= write_en_d;
      init_done_q  <= init_done_d;
    end
  end

  assign bus.alu_gnt_o    = alu_win;
  assign bus.lsu_gnt_o    = lsu_win;
  assign bus.write_addr_o = write_addr_q;
  assign bus.write_data_o = write_data_q;
  assign bus.write_en_o   = write_en_q;
  assign bus.init_done_o  = init_done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: requester model plus arbitration
// reference drives a scoreboard of expected writes; a separate monitor
// pops and compares every write the DUT presents.
module tb_rf_write_arbiter;

  localparam int AW    = 5;
  localparam int WW    = 32;
  localparam int LIMIT = 4;
  localparam int BIG   = 1_000_000;

  typedef struct {
    int unsigned   stamp;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  typedef struct {
    bit            active;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } rq_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rf_write_arbiter_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  rf_write_arbiter #(
    .ADDR_WIDTH  (AW),
    .WORD_WIDTH  (WW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  wr_t           exp_q[$];
  rq_t           alu, lsu;
  int unsigned   cycle      = 0;
  int unsigned   run_start  = BIG;
  int unsigned   alu_losses = 0;
  int            n_checks   = 0;
  int            n_errors   = 0;
  logic [AW-1:0] last_addr  = '0;
  logic [WW-1:0] last_data  = '0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every presented write must match the oldest expected one,
  // in the exact cycle it is due; idle cycles must hold the last write.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].stamp < cycle) begin
        w = exp_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missing_write: addr 0x%0h data 0x%0h due cycle %0d not seen", w.addr, w.data, w.stamp);
      end
      if (bus.write_en_o) begin
        if (exp_q.size() == 0 || exp_q[0].stamp != cycle) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d, none due", bus.write_addr_o, bus.write_data_o, cycle);
        end else begin
          w = exp_q.pop_front();
          check("write_addr", bus.write_addr_o, w.addr);
          check("write_data", bus.write_data_o, w.data);
          last_addr = w.addr;
          last_data = w.data;
        end
      end else begin
        check("hold_addr", bus.write_addr_o, last_addr);
        check("hold_data", bus.write_data_o, last_data);
      end
      check("init_done", bus.init_done_o, (cycle >= run_start + 1));
    end
  end

  // One clock: drive current requests, then at the falling edge apply the
  // arbitration rules and retire whichever requester was granted.
  task automatic step();
    bit ea, el;
    @(posedge clk);
    #1;
    bus.alu_req_i  = alu.active;
    bus.alu_addr_i = alu.addr;
    bus.alu_data_i = alu.data;
    bus.lsu_req_i  = lsu.active;
    bus.lsu_addr_i = lsu.addr;
    bus.lsu_data_i = lsu.data;
    @(negedge clk);
    ea = 1'b0;
    el = 1'b0;
    if (rst_n && cycle >= run_start) begin
      if (alu.active && lsu.active) begin
        if (alu_losses == LIMIT) ea = 1'b1;
        else                     el = 1'b1;
      end else begin
        ea = alu.active;
        el = lsu.active;
      end
    end
    check("alu_gnt", bus.alu_gnt_o, ea);
    check("lsu_gnt", bus.lsu_gnt_o, el);
    if (ea) begin
      alu_losses = 0;
      if (alu.addr != '0) exp_q.push_back('{cycle + 1, alu.addr, alu.data});
      alu.active = 1'b0;
    end
    if (el) begin
      if (alu.active) alu_losses++;
      if (lsu.addr != '0) exp_q.push_back('{cycle + 1, lsu.addr, lsu.data});
      lsu.active = 1'b0;
    end
  endtask

  // Release between edges; the clear sequence 1..31 is then due on
  // consecutive cycles, and RUN starts with the last clear on the port.
  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k < (1 << AW); k++) begin
      exp_q.push_back('{cycle + k, AW'(k), '0});
    end
    run_start = cycle + (1 << AW) - 1;
  endtask

  // Assert reset between edges and verify outputs clear without a clock.
  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_alu_gnt", bus.alu_gnt_o, 0);
    check("rst_lsu_gnt", bus.lsu_gnt_o, 0);
    check("rst_write_en", bus.write_en_o, 0);
    check("rst_write_addr", bus.write_addr_o, 0);
    check("rst_write_data", bus.write_data_o, 0);
    check("rst_init_done", bus.init_done_o, 0);
    exp_q.delete();
    last_addr  = '0;
    last_data  = '0;
    alu_losses = 0;
    run_start  = BIG;
    alu.active = 1'b0;
    lsu.active = 1'b0;
    repeat (2) step();
  endtask

  function automatic rq_t rand_req();
    rq_t r;
    r.active = 1'b1;
    r.addr   = AW'($urandom_range(0, (1 << AW) - 1));
    r.data   = $urandom;
    return r;
  endfunction

  initial begin
    alu = '{1'b0, '0, '0};
    lsu = '{1'b0, '0, '0};
    bus.alu_req_i  = 1'b0;
    bus.alu_addr_i = '0;
    bus.alu_data_i = '0;
    bus.lsu_req_i  = 1'b0;
    bus.lsu_addr_i = '0;
    bus.lsu_data_i = '0;

    // Reset state, held across several edges
    repeat (3) step();
    check("reset_write_en", bus.write_en_o, 0);
    check("reset_write_addr", bus.write_addr_o, 0);
    check("reset_write_data", bus.write_data_o, 0);
    check("reset_init_done", bus.init_done_o, 0);

    // Clear sequence with no requests, then idle
    release_reset();
    repeat (36) step();

    // ALU request held from INIT is granted in the first RUN cycle
    apply_reset();
    alu = '{1'b1, AW'(5), 32'hDEADBEEF};
    release_reset();
    repeat (34) step();

    // Write to register 0 completes the handshake but is dropped
    lsu = '{1'b1, '0, 32'h0000_1234};
    step();
    step();

    // Alternating single requests: no bubbles
    alu = '{1'b1, AW'(3), 32'h0000_0333};
    step();
    lsu = '{1'b1, AW'(4), 32'h0000_0444};
    step();
    alu = '{1'b1, AW'(7), 32'h0000_0777};
    step();
    step();

    // Continuous contention: LSU x LIMIT, then ALU, repeating
    for (int k = 0; k < 4 * (LIMIT + 1); k++) begin
      if (!alu.active) alu = rand_req();
      if (!lsu.active) lsu = rand_req();
      step();
      check("starve_pattern_alu", bus.alu_gnt_o, (k % (LIMIT + 1)) == LIMIT);
    end
    repeat (3) step();

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      if (!alu.active && ($urandom_range(0, 9) < 6)) alu = rand_req();
      if (!lsu.active && ($urandom_range(0, 9) < 6)) lsu = rand_req();
      step();
    end
    repeat (4) step();

    // Reset during a grant cycle: the granted write must never appear
    alu = '{1'b1, AW'(9), 32'h0000_CAFE};
    lsu = '{1'b1, AW'(10), 32'h0000_F00D};
    step();
    apply_reset();
    release_reset();
    repeat (36) step();

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive ALU losses before the ALU is forced a win (range 1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port alu_req_i, input, 1, ALU writeback request.
REQ-007 SHALL have port alu_addr_i, input, ADDR_WIDTH, ALU destination register.
REQ-008 SHALL have port alu_data_i, input, WORD_WIDTH, ALU result.
REQ-009 SHALL have port alu_gnt_o, output, 1, ALU request accepted this cycle.
REQ-010 SHALL have port lsu_req_i, input, 1, load-unit writeback request.
REQ-011 SHALL have port lsu_addr_i, input, ADDR_WIDTH, load destination register.
REQ-012 SHALL have port lsu_data_i, input, WORD_WIDTH, load data.
REQ-013 SHALL have port lsu_gnt_o, output, 1, LSU request accepted this cycle.
REQ-014 SHALL have port write_addr_o, output, ADDR_WIDTH, register bank write address.
REQ-015 SHALL have port write_data_o, output, WORD_WIDTH, register bank write data.
REQ-016 SHALL have port write_en_o, output, 1, register bank write enable.
REQ-017 SHALL have port init_done_o, output, 1, high once register clearing is complete.

Function
REQ-018 SHALL implement a two-state FSM: INIT (after reset) and RUN; INIT->RUN only after the last clear write; there is no RUN->INIT transition except by reset.
REQ-019 In INIT it SHALL drive one clear write per cycle, with write_data_o=0 and write_addr_o stepping 1,2,...,31, write_en_o=1, for 31 cycles total; address 0 is never written.
REQ-020 In INIT both grants SHALL be 0 regardless of requests; requests are neither lost nor recorded.
REQ-021 init_done_o SHALL rise in the cycle after the address-31 clear write and stay high until reset.
REQ-022 In RUN the grants SHALL be combinational from the current requests: a requester holds req/addr/data stable until it sees its grant high, and the transfer occurs in that cycle.
REQ-023 At most one grant SHALL be high per cycle; a single requester is always granted.
REQ-024 On contention (both requests high) the LSU SHALL win unless the starvation counter equals STARVE_LIMIT, in which case the ALU wins.
REQ-025 The 4-bit starvation counter SHALL increment on each contention cycle lost by the ALU, clear whenever the ALU is granted, hold otherwise, and never exceed STARVE_LIMIT.
REQ-026 The write port SHALL be registered: the granted addr/data appear on write_addr_o/write_data_o one cycle after the grant, with write_en_o=1 for exactly that cycle.
REQ-027 A granted request to address 0 SHALL complete the handshake (grant=1) but produce write_en_o=0 in the following cycle.
REQ-028 With no grant in RUN, write_en_o SHALL be 0 the next cycle, and write_addr_o/write_data_o hold their last values.
REQ-029 Back-to-back grants SHALL sustain one write per cycle with no bubbles.

Reset
REQ-030 While rst_n=0: write_en_o=0, write_addr_o=0, write_data_o=0, alu_gnt_o=0, lsu_gnt_o=0, init_done_o=0, starvation counter=0, FSM=INIT with clear address=1.
REQ-031 Reset assertion mid-INIT or mid-RUN SHALL take effect immediately (asynchronously) and discard any pending registered write.
REQ-032 On release the next rising edge SHALL begin the clear sequence at address 1.

Verification
REQ-033 Release reset, no requests -> 31 writes of data 0 to addr 1..31 on consecutive cycles; init_done_o=1 on the next cycle; write_en_o=0 thereafter.
REQ-034 ALU req addr 5 data 0xDEADBEEF held from INIT -> alu_gnt_o first high in the first RUN cycle; next cycle write_en_o=1, addr 5, data 0xDEADBEEF.
REQ-035 Both requests continuous, STARVE_LIMIT=4 -> grant pattern LSU,LSU,LSU,LSU,ALU repeating; each grant is followed by a matching write one cycle later.
REQ-036 LSU req addr 0 data 0x1234 -> lsu_gnt_o=1; next cycle write_en_o=0.
REQ-037 rst_n pulsed low during a RUN grant cycle -> outputs zero immediately, no write of the granted data, and the clear sequence restarts from addr 1.
REQ-038 Alternating single requests ALU(addr 3), LSU(addr 4), ALU(addr 7) in consecutive cycles -> three consecutive writes to 3, 4, 7 with no bubble; the starvation counter stays 0.
